// File: rtl/gate_bist_if.sv
// gate_bist_if: request, result and gate-facing signals of the gate self-test.
// master is the controller/environment side, slave is the BIST block.
interface gate_bist_if;
    logic       start;
    logic       abort;
    logic [3:0] exp_tt;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [1:0] fail_vec;

    modport master (
        output start, abort, exp_tt, y,
        input  a, b, busy, done, pass, fail_count, fail_vec
    );

    modport slave (
        input  start, abort, exp_tt, y,
        output a, b, busy, done, pass, fail_count, fail_vec
    );
endinterface

// File: rtl/gate_bist.sv
// gate_bist: walks (a,b) through 00..11, settles, samples y and compares it
// with a captured truth table; reports pass, fail count and first bad vector.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic        clk,
    input logic        rst_n,
    gate_bist_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tt_q, tt_d;
    logic [1:0] ab_q, ab_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] fc_q, fc_d;
    logic [1:0] fv_q, fv_d;
    logic       first_q, first_d;

    // Next-state and registered-output logic for the self-test sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fc_d    = fc_q;
        fv_d    = fv_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tt_d    = bus.exp_tt;
                    ab_d    = 2'b00;
                    fc_d    = 3'd0;
                    fv_d    = 2'b00;
                    pass_d  = 1'b0;
                    first_d = 1'b0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    ab_d    = 2'b00;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (bus.abort) begin
                    ab_d    = 2'b00;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (bus.y != tt_q[ab_q]) begin
                        fc_d = fc_q + 3'd1;
                        if (!first_q) begin
                            fv_d    = ab_q;
                            first_d = 1'b1;
                        end
                    end
                    if (ab_q == 2'b11) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        ab_d    = ab_q + 2'b01;
                        cnt_d   = 4'd0;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                pass_d  = (fc_q == 3'd0);
                ab_d    = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tt_q    <= 4'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= 3'd0;
            fv_q    <= 2'b00;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            fv_q    <= fv_d;
            first_q <= first_d;
        end
    end

    assign bus.a          = ab_q[1];
    assign bus.b          = ab_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_count = fc_q;
    assign bus.fail_vec   = fv_q;
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: drives gate_bist against a modelled gate under test and
// checks every cycle against a schedule-based model plus literal checkpoints.
module tb_gate_bist;
    localparam int S = 2;
    localparam int P = S + 1;
    localparam int N = 4 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gmode = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;

    gate_bist_if bif();

    gate_bist #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Gate under test: 0 = AND, 1 = stuck at 0, 2 = stuck at 1.
    assign bif.y = (gmode == 2'd0) ? (bif.a & bif.b) : (gmode == 2'd2);

    always #5 clk = ~clk;

    // Model state: m_d is the cycle offset since the accepting edge.
    bit         m_run  = 1'b0;
    int         m_d    = 0;
    logic [3:0] m_tt   = 4'd0;
    logic [1:0] m_ab   = 2'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_pass = 1'b0;
    logic [2:0] m_fc   = 3'd0;
    logic [1:0] m_fv   = 2'd0;

    function automatic logic gate_out(logic [1:0] k);
        case (gmode)
            2'd0:    return (k == 2'd3);
            2'd1:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] vec_at(int d);
        return 2'(d / P - 1);
    endfunction

    function automatic logic mis_at(int d);
        logic [1:0] k;
        if (d < P || d > N || (d % P) != 0) return 1'b0;
        k = vec_at(d);
        return gate_out(k) != m_tt[k];
    endfunction

    // Model of the expected outputs from the run schedule.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_d    <= 0;
            m_ab   <= 2'd0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pass <= 1'b0;
            m_fc   <= 3'd0;
            m_fv   <= 2'd0;
        end else if (!m_run) begin
            if (bif.start) begin
                m_run  <= 1'b1;
                m_d    <= 1;
                m_tt   <= bif.exp_tt;
                m_fc   <= 3'd0;
                m_fv   <= 2'd0;
                m_pass <= 1'b0;
                m_ab   <= 2'd0;
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end
        end else if (m_d == N + 1) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_pass <= (m_fc == 3'd0);
            m_ab   <= 2'd0;
        end else if (bif.abort) begin
            m_run  <= 1'b0;
            m_ab   <= 2'd0;
            m_busy <= 1'b0;
            m_pass <= 1'b0;
        end else begin
            if (mis_at(m_d)) begin
                m_fc <= m_fc + 3'd1;
                if (m_fc == 3'd0) m_fv <= vec_at(m_d);
            end
            m_d    <= m_d + 1;
            m_busy <= (m_d + 1 <= N);
            m_done <= (m_d + 1 == N + 1);
            m_ab   <= (m_d + 1 <= N) ? 2'(m_d / P) : 2'd3;
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for the coming edge (edge 0); returns in cycle 1.
    task automatic run_start(logic [3:0] tt);
        bif.start  = 1'b1;
        bif.exp_tt = tt;
        step(1);
        bif.start  = 1'b0;
    endtask

    function automatic int dut_word();
        return int'({bif.a, bif.b, bif.busy, bif.done, bif.pass,
                     bif.fail_count, bif.fail_vec});
    endfunction

    function automatic int mdl_word();
        return int'({m_ab, m_busy, m_done, m_pass, m_fc, m_fv});
    endfunction

    initial begin
        bif.start  = 1'b0;
        bif.abort  = 1'b0;
        bif.exp_tt = 4'b1000;
        @(posedge clk);
        fork
            forever begin
                @(negedge clk);
                chk("cycle", dut_word(), mdl_word());
            end
        join_none
        step(1);
        chk("rst_busy", int'(bif.busy), 0);
        chk("rst_fc", int'(bif.fail_count), 0);
        rst_n = 1'b1;
        step(1);

        // AND gate, exp_tt changed mid-run must not matter.
        gmode = 2'd0;
        run_start(4'b1000);
        bif.exp_tt = 4'b0111;
        chk("and_busy_c1", int'(bif.busy), 1);
        step(12);
        chk("and_done_c13", int'(bif.done), 1);
        chk("and_ab_c13", int'({bif.a, bif.b}), 3);
        step(1);
        chk("and_pass", int'(bif.pass), 1);
        chk("and_fc", int'(bif.fail_count), 0);
        chk("and_fv", int'(bif.fail_vec), 0);
        step(2);

        // y stuck at 0.
        gmode = 2'd1;
        run_start(4'b1000);
        step(13);
        chk("s0_pass", int'(bif.pass), 0);
        chk("s0_fc", int'(bif.fail_count), 1);
        chk("s0_fv", int'(bif.fail_vec), 3);

        // y stuck at 1, then a clean AND run clears results.
        gmode = 2'd2;
        run_start(4'b1000);
        step(13);
        chk("s1_pass", int'(bif.pass), 0);
        chk("s1_fc", int'(bif.fail_count), 3);
        chk("s1_fv", int'(bif.fail_vec), 0);
        gmode = 2'd0;
        run_start(4'b1000);
        chk("rerun_fc_c1", int'(bif.fail_count), 0);
        step(13);
        chk("rerun_pass", int'(bif.pass), 1);
        chk("rerun_fc", int'(bif.fail_count), 0);

        // start pulses at cycles 4 and 12 are ignored.
        run_start(4'b1000);
        step(3);
        bif.start = 1'b1;
        step(1);
        bif.start = 1'b0;
        step(7);
        bif.start = 1'b1;
        step(1);
        bif.start = 1'b0;
        chk("restart_done_c13", int'(bif.done), 1);
        step(1);
        chk("restart_done_c14", int'(bif.done), 0);
        chk("restart_busy_c14", int'(bif.busy), 0);
        step(1);

        // abort at cycle 5 keeps partial results, then start at cycle 8.
        gmode = 2'd2;
        run_start(4'b1000);
        step(4);
        bif.abort = 1'b1;
        step(1);
        bif.abort = 1'b0;
        chk("abort_busy_c6", int'(bif.busy), 0);
        chk("abort_ab_c6", int'({bif.a, bif.b}), 0);
        chk("abort_pass_c6", int'(bif.pass), 0);
        chk("abort_fc_c6", int'(bif.fail_count), 1);
        step(2);
        gmode = 2'd0;
        run_start(4'b1000);
        step(11);
        chk("abort_done_c20", int'(bif.done), 0);
        step(1);
        chk("abort_done_c21", int'(bif.done), 1);
        step(2);

        // start and abort together in IDLE: start wins.
        bif.start = 1'b1;
        bif.abort = 1'b1;
        bif.exp_tt = 4'b1000;
        step(1);
        bif.start = 1'b0;
        bif.abort = 1'b0;
        chk("start_wins_busy", int'(bif.busy), 1);
        step(14);

        // Reset at cycle 7 mid-run; start during reset is ignored.
        gmode = 2'd2;
        run_start(4'b1000);
        step(6);
        rst_n = 1'b0;
        bif.start = 1'b1;
        bif.exp_tt = 4'b0000;
        step(1);
        chk("rst_mid_busy", int'(bif.busy), 0);
        chk("rst_mid_fc", int'(bif.fail_count), 0);
        chk("rst_mid_ab", int'({bif.a, bif.b}), 0);
        step(1);
        rst_n = 1'b1;
        bif.start = 1'b0;
        step(1);
        chk("rst_after_busy", int'(bif.busy), 0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Hardware self-test controller for a 2-input combinational gate. It is the on-chip counterpart of a gate testbench.
- Drives all four input vectors (a,b) = 00, 01, 10, 11 into the gate under test, waits a settle time, samples y, and compares it against an expected truth table.
- Reports pass/fail, a fail count and the first failing vector.
- Sits beside the gate under test. It is started by a controller or top-level pin and its results are read back by software or a status register.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y is sampled; legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a run; accepted only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- exp_tt  input  4  expected truth table; bit index {a,b}, e.g. 4'b1000 for AND; captured on start.
- y  input  1  output of the gate under test.
- a  output  1  registered stimulus to the gate input a.
- b  output  1  registered stimulus to the gate input b.
- busy  output  1  high from the cycle after start acceptance until DONE.
- done  output  1  one-cycle pulse at end of a completed run.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next start is accepted.
- fail_count  output  3  mismatches in the last/current run, 0..4.
- fail_vec  output  2  {a,b} of the first mismatch; 0 if none.

Behaviour:
- Reset (rst_n=0 at clock edge), from any state including mid-run:
  - state = IDLE.
  - a=b=0, busy=0, done=0, pass=0, fail_count=0, fail_vec=0.
  - Internal captured table and settle counter are cleared.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - Outputs are held.
  - When start=1, in the same edge:
    - capture exp_tt;
    - {a,b} <= 00, fail_count <= 0, fail_vec <= 0, pass <= 0, first-fail flag cleared;
    - settle counter <= 0, busy <= 1, go to SETTLE.
- SETTLE:
  - The counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to CHECK.
- CHECK:
  - Sample y and compare against captured_tt[{a,b}].
  - On mismatch:
    - fail_count <= fail_count+1;
    - if this is the first mismatch of the run, fail_vec <= {a,b} and set the first-fail flag.
  - If {a,b} == 11, go to DONE.
  - Otherwise {a,b} <= {a,b}+1, counter <= 0, go to SETTLE.
- DONE:
  - done=1 for exactly one cycle.
  - busy <= 0; pass <= (fail_count == 0); {a,b} <= 00; go to IDLE.
  - pass, fail_count and fail_vec persist in IDLE.
- Timing, with start sampled at edge 0:
  - vector k is driven from cycle k(S+1)+1;
  - vector k is checked in cycle (k+1)(S+1);
  - done is high in cycle 4(S+1)+1, i.e. cycle 13 for S=2.
- Each vector is held for exactly S+1 cycles, and y is sampled in the last of them.
- Vector order is fixed: 00, 01, 10, 11. There is no wrap; the counter stops at 11.
- start while busy or in DONE is ignored, with no restart and no effect on results.
- abort=1 in SETTLE/CHECK:
  - next state IDLE; a=b=0, busy=0, done stays 0, pass=0;
  - fail_count/fail_vec keep their partial values.
- abort in IDLE/DONE is ignored.
- abort and start in the same IDLE cycle: start wins.
- exp_tt changes during a run have no effect; only the captured copy is used.
- fail_count saturates naturally at 4 (3-bit width); no overflow is possible.

Test Plan:
- AND gate under test, exp_tt=4'b1000, S=2, start at cycle 0 → a,b sequence 00, 01, 10, 11, each held 3 cycles; done=1 at cycle 13 only; pass=1, fail_count=0, fail_vec=00; busy high cycles 1..12.
- y stuck at 0, exp_tt=4'b1000 → pass=0, fail_count=1, fail_vec=11.
- y stuck at 1, exp_tt=4'b1000 → pass=0, fail_count=3, fail_vec=00; a second run with an AND gate under test → pass=1, fail_count=0 (results cleared on start).
- start pulsed again at cycles 4 and 12 during a run → no restart; done still at cycle 13 only.
- abort at cycle 5 → busy=0 and a=b=0 at cycle 6; done never pulses; pass=0. A new start at cycle 8 runs a full sequence with done at cycle 21.
- rst_n=0 at cycle 7 mid-run → all outputs at reset values the next cycle; start and exp_tt changes applied during reset are ignored.
